simplebus_master: RTL and testbench

SIMPLEBUS_MASTER -- requirements
Module: simplebus_master

---
 rtl/simplebus_pkg.sv | 32 +++
 rtl/simplebus_master_if.sv | 28 ++
 rtl/simplebus_master.sv | 169 ++++++++++++++++
 tb/tb_simplebus_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplebus_pkg.sv
// Shared constants, state encoding and parity helper for the simple-bus
// master: opcode values, frame geometry and the odd-parity rule applied
// to every byte in both directions.
package simplebus_pkg;

  localparam logic [7:0] OP_READ      = 8'h02;
  localparam logic [7:0] OP_WRITE     = 8'h03;
  localparam logic [7:0] OP_READ_ACK  = 8'h82;
  localparam logic [7:0] OP_WRITE_ACK = 8'h83;

  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 8;

  // Outgoing frame lengths: opcode + address (+ select + data for writes).
  localparam int RD_LEN = 1 + ADDR_BYTES;
  localparam int WR_LEN = 1 + ADDR_BYTES + 1 + DATA_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    RECV_DATA,
    RESP
  } state_e;

  // Odd parity: the parity bit makes the total count of ones in
  // {byte, parity} odd, i.e. it is the XNOR-reduction of the byte.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/simplebus_master_if.sv
// Wishbone-style request/response signals between a host and the
// simple-bus master. Signal names carry the direction as seen by the
// master block (its slave side), so the DUT uses the slave modport.
interface simplebus_master_if;

  logic [31:0] wb_adr_i;
  logic [63:0] wb_dat_i;
  logic [7:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [63:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;

  // Host side: issues requests, observes data/ack/stall.
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  // Bus-master side: accepts requests, returns data/ack/stall.
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );

endinterface

// File: rtl/simplebus_master.sv
// Bridges single Wishbone requests onto a byte-wide external bus.
// A request is serialised as opcode/address(/select/data) one byte per
// cycle, then the block waits for the device's ack opcode (with timeout),
// collects 8 read-data bytes for reads, and returns one ack pulse.
// Protocol, parity and timeout problems are recorded in sticky flags.
module simplebus_master
  import simplebus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  simplebus_master_if.slave   wb,
  output logic [7:0]          bus_out,
  output logic                bus_pty_out,
  input  logic [7:0]          bus_in,
  input  logic                bus_pty_in,
  output logic [2:0]          err_o,
  input  logic                err_clr_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    SEL_IDX   = 4'(1 + ADDR_BYTES);
  localparam logic [3:0]    DATA_IDX  = 4'(2 + ADDR_BYTES);
  localparam logic [3:0]    LAST_RX   = 4'(DATA_BYTES - 1);

  state_e        state_q;
  logic [3:0]    idx_q;      // shared byte index for SEND and RECV_DATA
  logic [31:0]   adr_q;
  logic [63:0]   buf_q;      // write data on the way out, read data on the way in
  logic [7:0]    sel_q;
  logic          we_q;
  logic [63:0]   rdata_q;    // last completed read, held for the host
  logic [7:0]    bus_out_q;
  logic          ack_q;
  logic [TW-1:0] tmo_q;
  logic [2:0]    err_q;      // {timeout, protocol, parity}

  logic [7:0]    tx_byte;
  logic [7:0]    rx_byte;
  logic [7:0]    exp_ack;
  logic [3:0]    frame_len;
  logic          pty_bad;
  logic          ack_hit;
  logic          proto_ev;
  logic          tmo_ev;

  // Incoming byte checks; a corrupted byte reads as "nothing yet" while
  // waiting for the ack so it can never be mistaken for an opcode.
  assign pty_bad   = (bus_pty_in != odd_parity(bus_in));
  assign rx_byte   = pty_bad ? 8'h00 : bus_in;
  assign exp_ack   = we_q ? OP_WRITE_ACK : OP_READ_ACK;
  assign frame_len = we_q ? 4'(WR_LEN) : 4'(RD_LEN);
  assign ack_hit   = (state_q == WAIT_ACK) && (rx_byte == exp_ack);
  assign proto_ev  = (state_q == WAIT_ACK) && (rx_byte != 8'h00) &&
                     (rx_byte != exp_ack);
  assign tmo_ev    = (state_q == WAIT_ACK) && !ack_hit && (tmo_q == TMO_LAST);

  // Select the outgoing byte for the current frame position (1..13).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    tx_byte = 8'h00;
    if (idx_q < SEL_IDX) begin
      tx_byte = 8'(adr_q >> {idx_q - 4'd1, 3'b000});
    end else if (idx_q == SEL_IDX) begin
      tx_byte = sel_q;
    end else begin
      tx_byte = 8'(buf_q >> {idx_q - DATA_IDX, 3'b000});
    end
  end

  // Transaction FSM: accept, serialise, await ack, collect data, respond.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register sees pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      adr_q     <= '0;
      buf_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      ack_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wb.wb_cyc_i && wb.wb_stb_i) begin
            adr_q     <= wb.wb_adr_i;
            buf_q     <= wb.wb_dat_i;
            sel_q     <= wb.wb_sel_i;
            we_q      <= wb.wb_we_i;
            bus_out_q <= wb.wb_we_i ? OP_WRITE : OP_READ;
            idx_q     <= 4'd1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (idx_q == frame_len) begin
            bus_out_q <= 8'h00;
            tmo_q     <= '0;
            state_q   <= WAIT_ACK;
          end else begin
            bus_out_q <= tx_byte;
            idx_q     <= idx_q + 4'd1;
          end
        end
        WAIT_ACK: begin
          if (ack_hit) begin
            if (we_q) begin
              ack_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              idx_q   <= '0;
              state_q <= RECV_DATA;
            end
          end else if (tmo_ev) begin
            rdata_q <= '1;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RECV_DATA: begin
          // Bytes arrive LSB first; shift in at the top. Corrupted bytes
          // are kept as received, only the parity flag records them.
          buf_q <= {bus_in, buf_q[63:8]};
          idx_q <= idx_q + 4'd1;
          if (idx_q == LAST_RX) begin
            rdata_q <= {bus_in, buf_q[63:8]};
            ack_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the clear cycle still sets its flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= (err_clr_i ? 3'b000 : err_q) | {tmo_ev, proto_ev, pty_bad};
    end
  end

  // The bus sequence always completes; only the host-visible ack is
  // withheld if the host abandoned the cycle.
  assign wb.wb_ack_o   = ack_q & wb.wb_cyc_i;
  assign wb.wb_stall_o = (state_q != IDLE);
  assign wb.wb_dat_o   = rdata_q;
  assign bus_out       = bus_out_q;
  assign bus_pty_out   = odd_parity(bus_out_q);
  assign err_o         = err_q;

endmodule

// File: tb/tb_simplebus_master.sv
// Directed bench for simplebus_master: expected bus bytes and expected
// host read data are queued when stimulus is driven and popped when the
// DUT presents them. Inputs change and outputs are sampled on negedges.
module tb_simplebus_master;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_out;
  logic       bus_pty_out;
  logic [7:0] bus_in;
  logic       bus_pty_in;
  logic [2:0] err_o;
  logic       err_clr_i;

  simplebus_master_if wb ();

  simplebus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .bus_out     (bus_out),
    .bus_pty_out (bus_pty_out),
    .bus_in      (bus_in),
    .bus_pty_in  (bus_pty_in),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_q[$];   // bytes the DUT must put on bus_out
  logic [8:0]  dev_q[$];   // device reply: {bad_parity, byte}
  logic [63:0] rsp_q[$];   // wb_dat_o expected at each ack

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic exp_parity(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Present a request and queue the frame it must produce.
  task automatic start_req(input logic we, input logic [31:0] adr,
                           input logic [63:0] dat, input logic [7:0] sel);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
    exp_q.push_back(we ? 8'h03 : 8'h02);
    for (int i = 0; i < 4; i++) exp_q.push_back(adr[8*i +: 8]);
    if (we) begin
      exp_q.push_back(sel);
      for (int i = 0; i < 8; i++) exp_q.push_back(dat[8*i +: 8]);
    end
  endtask

  // Compare the serialised frame byte by byte, then the quiet bus.
  task automatic check_frame(input bit keep_stb);
    logic [7:0] b;
    @(negedge clk);
    if (!keep_stb) wb.wb_stb_i = 1'b0;
    while (exp_q.size() != 0) begin
      b = exp_q.pop_front();
      check("bus_byte", bus_out, b);
      check("bus_pty", bus_pty_out, exp_parity(b));
      check("stall_busy", wb.wb_stall_o, 1);
      @(negedge clk);
    end
    check("bus_quiet", bus_out, 0);
    check("stall_wait", wb.wb_stall_o, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check("no_ack", wb.wb_ack_o, 0);
    end
  endtask

  task automatic check_ack();
    logic [63:0] e;
    check("ack_pulse", wb.wb_ack_o, 1);
    e = rsp_q.pop_front();
    check("dat_o", wb.wb_dat_o, e);
    @(negedge clk);
    check("ack_single", wb.wb_ack_o, 0);
    check("stall_idle", wb.wb_stall_o, 0);
  endtask

  // Drive the queued device bytes on consecutive cycles, then expect ack.
  task automatic reply();
    logic [8:0] e;
    while (dev_q.size() != 0) begin
      e = dev_q.pop_front();
      bus_in     = e[7:0];
      bus_pty_in = e[8] ? ~exp_parity(e[7:0]) : exp_parity(e[7:0]);
      @(negedge clk);
      if (dev_q.size() != 0) begin
        check("ack_early", wb.wb_ack_o, 0);
        check("stall_rx", wb.wb_stall_o, 1);
      end
    end
    bus_in     = 8'h00;
    bus_pty_in = 1'b1;
    check_ack();
  endtask

  task automatic clr_err();
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    check("err_cleared", err_o, 3'b000);
  endtask

  initial begin
    logic [7:0] b;
    rst         = 1'b1;
    err_clr_i   = 1'b0;
    bus_in      = 8'h00;
    bus_pty_in  = 1'b1;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_sel_i = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_bus", bus_out, 0);
    check("rst_pty", bus_pty_out, 1);
    check("rst_ack", wb.wb_ack_o, 0);
    check("rst_stall", wb.wb_stall_o, 0);
    check("rst_dat", wb.wb_dat_o, 0);
    check("rst_err", err_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write, device acks three cycles after the last byte.
    start_req(1'b1, 32'h12345678, 64'h1122334455667788, 8'hFF);
    check_frame(1'b0);
    rsp_q.push_back(64'h0);
    wait_cycles(2);
    dev_q.push_back({1'b0, 8'h83});
    reply();
    wb.wb_cyc_i = 1'b0;
    check("wr_err", err_o, 3'b000);

    // Read with 8-cycle response delay, data LSB first.
    start_req(1'b0, 32'hC0000010, 64'h0, 8'h00);
    check_frame(1'b0);
    wait_cycles(8);
    dev_q.push_back({1'b0, 8'h82});
    for (int i = 8; i >= 1; i--) dev_q.push_back({1'b0, 8'(i)});
    rsp_q.push_back(64'h0102030405060708);
    reply();
    wb.wb_cyc_i = 1'b0;

    // Read with no reply: timeout after TMO wait cycles.
    start_req(1'b0, 32'h00000040, 64'h0, 8'h00);
    check_frame(1'b0);
    rsp_q.push_back({64{1'b1}});
    wait_cycles(TMO - 1);
    @(negedge clk);
    check_ack();
    wb.wb_cyc_i = 1'b0;
    check("tmo_err", err_o, 3'b100);
    clr_err();

    // Stray byte, bad-parity ack, then good ack.
    start_req(1'b1, 32'hA5A50001, 64'hDEADBEEF0BADF00D, 8'h0F);
    check_frame(1'b0);
    dev_q.push_back({1'b0, 8'h55});
    dev_q.push_back({1'b1, 8'h83});
    dev_q.push_back({1'b0, 8'h83});
    rsp_q.push_back({64{1'b1}});
    reply();
    wb.wb_cyc_i = 1'b0;
    check("stray_err", err_o, 3'b011);
    clr_err();

    // Bad parity while idle, coinciding with clear: flag must win.
    err_clr_i  = 1'b1;
    bus_in     = 8'h01;
    bus_pty_in = 1'b1;
    @(negedge clk);
    err_clr_i  = 1'b0;
    bus_in     = 8'h00;
    check("clr_vs_err", err_o, 3'b001);
    clr_err();

    // Reset while the 6th write byte is on the bus.
    start_req(1'b1, 32'h12345678, 64'h1122334455667788, 8'hFF);
    @(negedge clk);
    wb.wb_stb_i = 1'b0;
    repeat (5) begin
      b = exp_q.pop_front();
      check("pre_rst_byte", bus_out, b);
      @(negedge clk);
    end
    check("sixth_byte", bus_out, exp_q.pop_front());
    exp_q.delete();
    rst         = 1'b1;
    wb.wb_cyc_i = 1'b0;
    #1;
    check("mid_rst_bus", bus_out, 0);
    check("mid_rst_pty", bus_pty_out, 1);
    check("mid_rst_stall", wb.wb_stall_o, 0);
    check("mid_rst_ack", wb.wb_ack_o, 0);
    check("mid_rst_dat", wb.wb_dat_o, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(3);
    check("post_rst_bus", bus_out, 0);
    start_req(1'b0, 32'h00001000, 64'h0, 8'h00);
    check_frame(1'b0);
    wait_cycles(1);
    dev_q.push_back({1'b0, 8'h82});
    for (int i = 0; i < 8; i++) dev_q.push_back({1'b0, 8'hA0 + 8'(i)});
    rsp_q.push_back(64'hA7A6A5A4A3A2A1A0);
    reply();
    wb.wb_cyc_i = 1'b0;

    // Back-to-back: stb held, second request waits for the first ack.
    start_req(1'b0, 32'h00002000, 64'h0, 8'h00);
    check_frame(1'b1);
    start_req(1'b1, 32'h00003000, 64'h0123456789ABCDEF, 8'h3C);
    dev_q.push_back({1'b0, 8'h82});
    for (int i = 0; i < 8; i++) dev_q.push_back({1'b0, 8'h10 + 8'(i)});
    rsp_q.push_back(64'h1716151413121110);
    reply();
    check_frame(1'b0);
    dev_q.push_back({1'b0, 8'h83});
    rsp_q.push_back(64'h1716151413121110);
    reply();
    wb.wb_cyc_i = 1'b0;
    check("final_err", err_o, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "simulation time limit reached");
  end

endmodule
